traffic_light_ctrl: RTL

Two-way intersection traffic-light controller with a pedestrian-walk phase. It runs on the 50 MHz system clock and consumes the 1 Hz square wave produced by the clock divider as its seconds timebase. Each rising edge of that wave is one "tick". The light outputs drive board LEDs directly, and the remaining-seconds count feeds the display stage.

---
 rtl/traffic_light_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection light sequencer with a pedestrian walk phase.
// Each rising edge of the 1 Hz tick_in is one tick; every state lasts its duration in ticks.
//
// state   | code | meaning
// --------+------+-----------------------------------------------
// RED_CLR |  0   | all-red clearance between phases
// MAIN_G  |  1   | main road green
// MAIN_Y  |  2   | main road yellow
// SIDE_G  |  3   | side road green
// SIDE_Y  |  4   | side road yellow
// WALK    |  5   | pedestrian walk, all roads red
module traffic_light_ctrl #(
  parameter int MAIN_GREEN_S = 10,
  parameter int SIDE_GREEN_S = 6,
  parameter int YELLOW_S     = 3,
  parameter int ALL_RED_S    = 1,
  parameter int WALK_S       = 5,
  parameter int CNT_W        = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             ped_req,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             ped_walk,
  output logic             ped_ack,
  output logic             ped_pending,
  output logic [CNT_W-1:0] remaining,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    RED_CLR = 3'd0,
    MAIN_G  = 3'd1,
    MAIN_Y  = 3'd2,
    SIDE_G  = 3'd3,
    SIDE_Y  = 3'd4,
    WALK    = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] rem_nxt;
  logic             next_side;
  logic             next_side_nxt;

  logic             tick_d;
  logic             tick_pulse;
  logic             tick_q;
  logic             ped_s1;
  logic             ped_s2;
  logic             ped_s3;
  logic             ped_edge;
  logic             walk_entry;

  function automatic logic [CNT_W-1:0] dur_of(input state_t st);
    logic [CNT_W-1:0] d;
    case (st)
      MAIN_G:  d = CNT_W'(MAIN_GREEN_S);
      MAIN_Y:  d = CNT_W'(YELLOW_S);
      SIDE_G:  d = CNT_W'(SIDE_GREEN_S);
      SIDE_Y:  d = CNT_W'(YELLOW_S);
      WALK:    d = CNT_W'(WALK_S);
      default: d = CNT_W'(ALL_RED_S);
    endcase
    return d;
  endfunction

  // {main, side, walk}; only one road ever sees green or yellow
  function automatic logic [6:0] lamps_of(input state_t st);
    logic [6:0] l;
    case (st)
      MAIN_G:  l = {LAMP_GRN, LAMP_RED, 1'b0};
      MAIN_Y:  l = {LAMP_YEL, LAMP_RED, 1'b0};
      SIDE_G:  l = {LAMP_RED, LAMP_GRN, 1'b0};
      SIDE_Y:  l = {LAMP_RED, LAMP_YEL, 1'b0};
      WALK:    l = {LAMP_RED, LAMP_RED, 1'b1};
      default: l = {LAMP_RED, LAMP_RED, 1'b0};
    endcase
    return l;
  endfunction

  assign tick_pulse = tick_in & ~tick_d;
  assign tick_q     = tick_pulse & enable;
  assign ped_edge   = ped_s2 & ~ped_s3;

  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    next_side_nxt = next_side;
    case (state)
      RED_CLR, MAIN_G, MAIN_Y, SIDE_G, SIDE_Y, WALK: begin
        if (tick_q) begin
          if (rem == CNT_W'(1)) begin
            case (state)
              RED_CLR: begin
                if (ped_pending)    state_nxt = WALK;
                else if (next_side) state_nxt = SIDE_G;
                else                state_nxt = MAIN_G;
              end
              MAIN_G:  state_nxt = MAIN_Y;
              MAIN_Y: begin
                state_nxt     = RED_CLR;
                next_side_nxt = 1'b1;
              end
              SIDE_G:  state_nxt = SIDE_Y;
              SIDE_Y: begin
                state_nxt     = RED_CLR;
                next_side_nxt = 1'b0;
              end
              default: state_nxt = RED_CLR;
            endcase
            rem_nxt = dur_of(state_nxt);
          end else begin
            rem_nxt = rem - CNT_W'(1);
          end
        end
      end
      // codes 6 and 7 are unreachable except by upset; fall back to clearance
      default: begin
        state_nxt = RED_CLR;
        rem_nxt   = CNT_W'(ALL_RED_S);
      end
    endcase
  end

  assign walk_entry = (state_nxt == WALK) && (state != WALK);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RED_CLR;
      rem         <= CNT_W'(ALL_RED_S);
      next_side   <= 1'b0;
      tick_d      <= 1'b0;
      ped_s1      <= 1'b0;
      ped_s2      <= 1'b0;
      ped_s3      <= 1'b0;
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
      main_light  <= LAMP_RED;
      side_light  <= LAMP_RED;
      ped_walk    <= 1'b0;
    end else begin
      tick_d    <= tick_in;
      ped_s1    <= ped_req;
      ped_s2    <= ped_s1;
      ped_s3    <= ped_s2;
      state     <= state_nxt;
      rem       <= rem_nxt;
      next_side <= next_side_nxt;
      ped_ack   <= walk_entry;
      // clearing on walk entry takes priority over a coincident button edge
      if (walk_entry)
        ped_pending <= 1'b0;
      else if (ped_edge && state != WALK)
        ped_pending <= 1'b1;
      {main_light, side_light, ped_walk} <= lamps_of(state_nxt);
    end
  end

  assign remaining = rem;
  assign state_o   = state;

endmodule
